// File: rtl/zx48_sdr_pkg.sv
// Shared types and widths for the SDRAM arbiter slice.
package zx48_sdr_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    GNT_RF,
    GNT_P0,
    GNT_P1
  } gnt_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh request generator merged with an external refresh pulse.
module sdram_refresh_timer #(
  parameter int RFSH_PERIOD = 430
) (
  input  logic clock,
  input  logic reset,
  input  logic ready,
  input  logic rfsh_req,
  input  logic clr,
  output logic pend
);

  localparam int CNT_W = (RFSH_PERIOD > 2) ? $clog2(RFSH_PERIOD) : 1;

  logic [CNT_W-1:0] cnt;
  logic             pend_q;
  logic             wrap;

  assign wrap = ready && (cnt == CNT_W'(RFSH_PERIOD - 1));

  // A wrap or pulse is visible to the arbiter in the cycle it happens, so a
  // grant in that cycle consumes it and no second refresh is left behind.
  assign pend = pend_q | wrap | rfsh_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      pend_q <= 1'b0;
    end else begin
      if (ready) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
      if (clr) begin
        pend_q <= 1'b0;
      end else if (wrap || rfsh_req) begin
        pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates refresh, CPU port 0 and DMA port 1 onto one SDRAM controller
// port, serialising every access into a fixed-length slot.
module sdram_arbiter
  import zx48_sdr_pkg::*;
#(
  parameter int SLOT        = 8,
  parameter int RFSH_PERIOD = 430,
  parameter int STARVE      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ready,
  input  logic              rfshReq,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] a0,
  input  logic [DATA_W-1:0] d0,
  output logic [DATA_W-1:0] q0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] a1,
  input  logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] q1,
  output logic              ack1,
  output logic              sdrRf,
  output logic              sdrRd,
  output logic              sdrWr,
  output logic [ADDR_W-1:0] sdrA,
  output logic [DATA_W-1:0] sdrD,
  input  logic [DATA_W-1:0] sdrQ,
  output logic              busy
);

  localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

  if (SLOT < 2 || SLOT > 255) begin : g_slot_range
    $error("sdram_arbiter: SLOT must be in 2..255");
  end

  state_t        state, state_nxt;
  gnt_t          gnt, gnt_sel;
  logic          take;
  logic          rf_clr;
  logic          rf_pend;
  logic          we_l;
  logic          wait_done;
  logic          starved;
  logic [7:0]    wcnt;
  logic [SW-1:0] starve;

  sdram_refresh_timer #(
    .RFSH_PERIOD(RFSH_PERIOD)
  ) u_rfsh (
    .clock    (clock),
    .reset    (reset),
    .ready    (ready),
    .rfsh_req (rfshReq),
    .clr      (rf_clr),
    .pend     (rf_pend)
  );

  assign wait_done = (wcnt == 8'(SLOT - 2));
  assign starved   = req1 && (starve == SW'(STARVE));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    gnt_sel   = GNT_P0;
    rf_clr    = 1'b0;
    sdrRf     = 1'b0;
    sdrRd     = 1'b0;
    sdrWr     = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (ready) begin
          if (rf_pend) begin
            take    = 1'b1;
            gnt_sel = GNT_RF;
            rf_clr  = 1'b1;
          end else if (starved) begin
            take    = 1'b1;
            gnt_sel = GNT_P1;
          end else if (req0) begin
            take    = 1'b1;
            gnt_sel = GNT_P0;
          end else if (req1) begin
            take    = 1'b1;
            gnt_sel = GNT_P1;
          end
        end
        if (take) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        sdrRf     = (gnt == GNT_RF);
        sdrRd     = (gnt != GNT_RF) && !we_l;
        sdrWr     = (gnt != GNT_RF) && we_l;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_done) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ack0      = (gnt == GNT_P0);
        ack1      = (gnt == GNT_P1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, slot timer, starvation tracking and read-data capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt    <= GNT_RF;
      we_l   <= 1'b0;
      sdrA   <= '0;
      sdrD   <= '0;
      q0     <= '0;
      q1     <= '0;
      starve <= '0;
      wcnt   <= '0;
    end else begin
      if (take) begin
        gnt <= gnt_sel;
        case (gnt_sel)
          GNT_P0: begin
            we_l <= we0;
            sdrA <= a0;
            sdrD <= d0;
            if (req1 && (starve != SW'(STARVE))) begin
              starve <= starve + 1'b1;
            end
          end
          GNT_P1: begin
            we_l   <= we1;
            sdrA   <= a1;
            sdrD   <= d1;
            starve <= '0;
          end
          default: we_l <= 1'b0;
        endcase
      end

      if (state == ISSUE) begin
        wcnt <= '0;
      end else if (state == WAIT) begin
        wcnt <= wcnt + 1'b1;
      end

      if ((state == WAIT) && wait_done && !we_l) begin
        if (gnt == GNT_P0) begin
          q0 <= sdrQ;
        end else if (gnt == GNT_P1) begin
          q1 <= sdrQ;
        end
      end
    end
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Shares the single SDRAM controller port between two requesters and the refresh scheduler. Port 0 is the CPU/main memory path and has priority. Port 1 is a secondary DMA-style requester, such as a loader or video fetch. The block sits between the requesters and the sdram controller, driving its refresh/read/write strobes, address and write data. It serialises every access into a fixed-length slot.

Parameters:
SLOT, 8, clocks from the command strobe cycle to sdrQ valid / command complete; legal range 2..255 (elaboration error outside this).
RFSH_PERIOD, 430, clocks between internal refresh requests (about 7.7 us at 56 MHz).
STARVE, 4, consecutive port-0 grants made while port 1 waits before port 1 is forced to win.

Ports:
clock  in  1  system clock (56 MHz)
reset  in  1  synchronous reset, active-high
ready  in  1  sdram controller initialisation done
rfshReq  in  1  external refresh request pulse
req0  in  1  port 0 request (level)
we0  in  1  port 0: 1 = write, 0 = read
a0  in  24  port 0 address
d0  in  16  port 0 write data
q0  out  16  port 0 read data
ack0  out  1  port 0 completion pulse
req1, we1, a1, d1, q1, ack1  same as port 0, for port 1
sdrRf  out  1  refresh strobe to controller
sdrRd  out  1  read strobe to controller
sdrWr  out  1  write strobe to controller
sdrA  out  24  address to controller
sdrD  out  16  write data to controller
sdrQ  in  16  read data from controller
busy  out  1  high when state is not IDLE

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - All strobes, acks and busy = 0.
  - q0, q1, sdrA, sdrD = 0.
  - Refresh counter, refresh pending flag and starve counter = 0.
- Reset mid-slot aborts immediately: strobes are low the next cycle, no ack is issued, and the granted request is dropped. A requester still holding req is served again after reset.
- Refresh timer:
  - Counts only while ready is high.
  - At RFSH_PERIOD-1 it wraps to 0 and sets rfshPend.
  - An rfshReq pulse also sets rfshPend. Timer wrap and pulse in the same cycle set a single pending refresh.
  - rfshPend clears on the cycle its refresh slot is granted. A new request arriving during that slot re-sets it.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - With ready low, stay in IDLE.
  - Otherwise arbitrate in this order: rfshPend; then req1 if req1 and starve == STARVE; then req0; then req1.
  - On a grant, latch the grant, the we bit, the address into sdrA and the data into sdrD, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (1 cycle):
  - Exactly one of sdrRf, sdrRd or sdrWr is high.
  - sdrA and sdrD are held stable from ISSUE until the return to IDLE.
- WAIT (SLOT-1 cycles):
  - All strobes are low.
  - On the edge ending the last WAIT cycle (SLOT cycles after the ISSUE cycle began), a read grant captures sdrQ into q0 or q1.
- DONE (1 cycle):
  - ack of the granted port is high for a read or write grant. A refresh slot gives no ack.
  - Next state is IDLE.
- Latency: req sampled in IDLE cycle k → strobe in k+1 → ack in k+SLOT+1 → IDLE in k+SLOT+2.
- Back-to-back slot period is SLOT+2 clocks.
- Handshake rules:
  - req is sampled only in IDLE.
  - The requester holds req, we, a and d stable until ack.
  - The requester deasserts req on the edge at which it sees ack. A registered clear is enough, because the DONE→IDLE edge coincides with it.
  - req still high in the IDLE cycle is a new request.
- A write leaves q unchanged. q holds its value until the next read for that port.
- Starve counter:
  - Increments, saturating at STARVE, when port 0 is granted while req1 is high.
  - Clears when port 1 is granted.
  - Is unchanged by refresh grants.
- ready dropping mid-slot: the current slot completes normally and no new grants are made.
- Simultaneous rfshPend, req0 and req1: refresh first, then port 0 (unless starved), then port 1.

Decomposition:
- Package zx48_sdr_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - grant enum (GNT_RF, GNT_P0, GNT_P1);
  - ADDR_W = 24, DATA_W = 16.
- One sub-module, sdram_refresh_timer: counter, wrap, rfshReq merge, pending flag and clear input.

Test Plan:
- SLOT=8, single port-0 read of a0=24'h000123 with sdrQ=16'hBEEF in the capture cycle → sdrRd high one cycle with sdrA=24'h000123; ack0 in k+9; q0=16'hBEEF; q1 unchanged.
- Port-1 write a1=24'h03FFFF, d1=16'h5A5A → sdrWr one pulse, sdrD=16'h5A5A held for the whole slot, ack1 once, q1 unchanged.
- req0 held continuously with req1 high, STARVE=4 → grant sequence P0,P0,P0,P0,P1,P0…; slot starts exactly 10 clocks apart.
- rfshReq, req0 and req1 asserted in the same cycle → refresh slot first (no ack), then P0, then P1.
- RFSH_PERIOD=20, idle bus → sdrRf pulses every 22 clocks at most, with no extra refresh when rfshReq coincides with timer wrap.
- reset asserted in the 3rd WAIT cycle of a read → next cycle: state IDLE, all outputs 0, no ack; request re-served after reset deasserts.
